// File: rtl/gray_step_tracker.sv
// gray_step_tracker
//   Synchronises a Gray-coded bus, decodes it to binary and checks that
//   every change is a single-bit Gray step. Reports step direction, counts
//   valid steps and enters a latched fault after ERR_LIMIT illegal steps
//   in a row.
//
//   Optional feature: define GRAY_TRACK_PARITY_EN to add the bin_par
//   output (even parity of bin_out, registered with it).
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_ACQUIRE | not tracking; loads the synchronised value when en=1
//   ST_TRACK   | bin_out valid; evaluates each Gray change
//   ST_FAULT   | too many illegal steps; outputs frozen until clr/rst
module gray_step_tracker #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_LIMIT   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] g_in,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] bin_out,
    output logic         bin_valid,
    output logic         dir_up,
    output logic [7:0]   step_cnt,
    output logic [3:0]   err_cnt,
    output logic         fault
`ifdef GRAY_TRACK_PARITY_EN
    ,
    output logic         bin_par
`endif
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] gs;
    logic [W-1:0] g_prev_q, g_prev_d;
    logic [W-1:0] bin_d;
    logic         dir_up_d;
    logic [7:0]   step_cnt_d;
    logic [3:0]   err_cnt_d;

    logic [W-1:0] gs_dec;
    logic [W-1:0] g_diff;
    logic         diff_zero;
    logic         diff_single;
    logic [7:0]   step_inc;
    logic [3:0]   err_inc;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchroniser chain; g_in may be asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= g_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gs     = sync_q[SYNC_STAGES-1];
    assign gs_dec = gray_to_bin(gs);
    assign g_diff = gs ^ g_prev_q;

    // A single-bit difference is a non-zero power of two.
    assign diff_zero   = (g_diff == '0);
    assign diff_single = !diff_zero && ((g_diff & (g_diff - W'(1))) == '0);

    assign step_inc = (step_cnt == 8'hFF) ? step_cnt : step_cnt + 8'd1;
    assign err_inc  = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;

    // Next-state and datapath decisions; clr outranks en and step evaluation.
    always_comb begin
        state_d    = state_q;
        g_prev_d   = g_prev_q;
        bin_d      = bin_out;
        dir_up_d   = dir_up;
        step_cnt_d = step_cnt;
        err_cnt_d  = err_cnt;

        if (clr) begin
            state_d    = ST_ACQUIRE;
            step_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (en) begin
                        g_prev_d = gs;
                        bin_d    = gs_dec;
                        state_d  = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!en) begin
                        state_d = ST_ACQUIRE;
                    end else if (diff_single) begin
                        g_prev_d   = gs;
                        bin_d      = gs_dec;
                        dir_up_d   = (gs_dec == bin_out + W'(1));
                        step_cnt_d = step_inc;
                        err_cnt_d  = '0;
                    end else if (!diff_zero) begin
                        err_cnt_d = err_inc;
                        if (int'(err_cnt) + 1 == ERR_LIMIT) begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_ACQUIRE;
                end
            endcase
        end
    end

    // State and tracked-value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ACQUIRE;
            g_prev_q <= '0;
            bin_out  <= '0;
            dir_up   <= 1'b0;
            step_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            g_prev_q <= g_prev_d;
            bin_out  <= bin_d;
            dir_up   <= dir_up_d;
            step_cnt <= step_cnt_d;
            err_cnt  <= err_cnt_d;
        end
    end

    assign bin_valid = (state_q == ST_TRACK);
    assign fault     = (state_q == ST_FAULT);

`ifdef GRAY_TRACK_PARITY_EN
    // Parity tracks the value being loaded into bin_out so both change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_par <= 1'b0;
        end else begin
            bin_par <= ^bin_d;
        end
    end
`endif

endmodule
